// File: rtl/memory_bus_master_pkg.sv
// Shared constants and FSM encoding for the memory bus initiator.
package memory_bus_master_pkg;

    localparam int   DATA_W   = 16;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_RD_DRAIN = 3'd2,
        ST_TURN     = 3'd3,
        ST_WR       = 3'd4,
        ST_WR_LAST  = 3'd5
    } state_t;

endpackage

// File: rtl/memory_bus_master.sv
// Bus initiator: turns valid/ready burst requests into registered bus cycles on a
// shared tristate data bus and captures read data from a registered-read memory.
module memory_bus_master
    import memory_bus_master_pkg::*;
#(
    parameter int address_size = 16,
    parameter int len_size     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [address_size-1:0] req_addr,
    input  logic [len_size-1:0]     req_len,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    busy,
    output logic [address_size-1:0] mem_address,
    output logic                    mem_read_write,
    output logic                    mem_enable,
    inout  wire  [DATA_W-1:0]       mem_data
);

    localparam logic [address_size-1:0] ADDR_ZERO = {address_size{1'b0}};
    localparam logic [address_size-1:0] ADDR_ONE  = {{(address_size-1){1'b0}}, 1'b1};
    localparam logic [len_size-1:0]     LEN_ZERO  = {len_size{1'b0}};
    localparam logic [len_size-1:0]     LEN_ONE   = {{(len_size-1){1'b0}}, 1'b1};

    state_t                  state_r, state_s;
    logic [address_size-1:0] mem_address_r, mem_address_s;
    logic [address_size-1:0] wr_addr_r, wr_addr_s;
    logic [len_size-1:0]     cnt_r, cnt_s;
    logic                    mem_enable_r, mem_enable_s;
    logic                    mem_read_write_r, mem_read_write_s;
    logic [DATA_W-1:0]       drive_r, drive_s;
    logic [DATA_W-1:0]       rd_data_r, rd_data_s;
    logic                    rd_valid_r, rd_valid_s;
    logic [1:0]              rd_pipe_r, rd_pipe_s;

    // State and all registered outputs; reset aborts any burst silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= ST_IDLE;
            mem_address_r    <= ADDR_ZERO;
            wr_addr_r        <= ADDR_ZERO;
            cnt_r            <= LEN_ZERO;
            mem_enable_r     <= 1'b0;
            mem_read_write_r <= RW_READ;
            drive_r          <= {DATA_W{1'b0}};
            rd_data_r        <= {DATA_W{1'b0}};
            rd_valid_r       <= 1'b0;
            rd_pipe_r        <= 2'b00;
        end else begin
            state_r          <= state_s;
            mem_address_r    <= mem_address_s;
            wr_addr_r        <= wr_addr_s;
            cnt_r            <= cnt_s;
            mem_enable_r     <= mem_enable_s;
            mem_read_write_r <= mem_read_write_s;
            drive_r          <= drive_s;
            rd_data_r        <= rd_data_s;
            rd_valid_r       <= rd_valid_s;
            rd_pipe_r        <= rd_pipe_s;
        end
    end

    // Next-state and next-output logic for the bus sequencer.
    always_comb begin
        state_s          = state_r;
        mem_address_s    = mem_address_r;
        wr_addr_s        = wr_addr_r;
        cnt_s            = cnt_r;
        mem_enable_s     = mem_enable_r;
        mem_read_write_s = mem_read_write_r;
        drive_s          = drive_r;
        // rd_pipe[0] marks an address issued this edge; data is on the bus two edges later.
        rd_pipe_s        = {rd_pipe_r[0], 1'b0};
        rd_valid_s       = rd_pipe_r[1];
        if (rd_pipe_r[1]) begin
            rd_data_s = mem_data;
        end else begin
            rd_data_s = rd_data_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_s = req_len;
                    if (req_write) begin
                        state_s          = ST_WR;
                        wr_addr_s        = req_addr;
                        mem_enable_s     = 1'b0;
                        mem_read_write_s = RW_READ;
                    end else begin
                        state_s          = ST_RD;
                        mem_address_s    = req_addr;
                        mem_enable_s     = 1'b1;
                        mem_read_write_s = RW_READ;
                        rd_pipe_s[0]     = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cnt_r != LEN_ZERO) begin
                    mem_address_s = mem_address_r + ADDR_ONE;
                    cnt_s         = cnt_r - LEN_ONE;
                    rd_pipe_s[0]  = 1'b1;
                end else begin
                    state_s = ST_RD_DRAIN;
                end
            end
            ST_RD_DRAIN: begin
                state_s          = ST_TURN;
                mem_enable_s     = 1'b0;
                mem_read_write_s = RW_READ;
            end
            ST_TURN: begin
                state_s = ST_IDLE;
            end
            ST_WR: begin
                if (wr_valid) begin
                    mem_address_s    = wr_addr_r;
                    wr_addr_s        = wr_addr_r + ADDR_ONE;
                    drive_s          = wr_data;
                    mem_enable_s     = 1'b1;
                    mem_read_write_s = RW_WRITE;
                    if (cnt_r == LEN_ZERO) begin
                        state_s = ST_WR_LAST;
                    end else begin
                        cnt_s = cnt_r - LEN_ONE;
                    end
                end else begin
                    mem_enable_s     = 1'b0;
                    mem_read_write_s = RW_READ;
                end
            end
            ST_WR_LAST: begin
                state_s          = ST_IDLE;
                mem_enable_s     = 1'b0;
                mem_read_write_s = RW_READ;
            end
            default: begin
                state_s          = ST_IDLE;
                mem_enable_s     = 1'b0;
                mem_read_write_s = RW_READ;
            end
        endcase
    end

    assign req_ready      = (state_r == ST_IDLE);
    assign wr_ready       = (state_r == ST_WR);
    assign busy           = (state_r != ST_IDLE);
    assign rd_valid       = rd_valid_r;
    assign rd_data        = rd_data_r;
    assign mem_address    = mem_address_r;
    assign mem_enable     = mem_enable_r;
    assign mem_read_write = mem_read_write_r;

    // Drive and memory-drive conditions come from the same registers, so they never overlap.
    assign mem_data = (mem_enable_r && (mem_read_write_r == RW_WRITE)) ? drive_r : {DATA_W{1'bz}};

endmodule
